// File: rtl/lot_pkg.sv
// Shared types and widths for the parking-lot occupancy counter.
package lot_pkg;

  localparam int COUNT_W = 7;
  localparam int BCD_W   = 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/bcd_updown_digit.sv
// One decimal digit of an up/down BCD counter; carry/borrow ripple to the next digit.
module bcd_updown_digit
  import lot_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [BCD_W-1:0] digit,
  output logic             carry,
  output logic             borrow
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  // NOTE: default assignment first so every path drives digit_d and no latch is inferred.
  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end else if (dec) begin
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign carry  = inc & (digit_q == 4'd9);
  assign borrow = dec & (digit_q == 4'd0);

endmodule

// File: rtl/lot_occupancy_counter.sv
// Saturating lot occupancy counter with edge-detected enter/exit, BCD display digits,
// empty/full state machine and sticky overflow/underflow flags.
module lot_occupancy_counter
  import lot_pkg::*;
#(
  parameter int CAPACITY = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enter,
  input  logic               exit,
  input  logic               clear,
  output logic [COUNT_W-1:0] count,
  output logic [BCD_W-1:0]   bcd_tens,
  output logic [BCD_W-1:0]   bcd_ones,
  output logic               empty,
  output logic               full,
  output logic               err_overflow,
  output logic               err_underflow
);

  localparam logic [COUNT_W-1:0] CAP = COUNT_W'(CAPACITY);

  logic enter_q, exit_q, enter_prev_q, exit_prev_q;
  logic ent_ev, ex_ev, only_ent, only_ex, inc, dec;
  logic [COUNT_W-1:0] count_q, count_d;
  occ_state_t state_q, state_d;
  logic empty_q, full_q, ovf_q, ovf_d, unf_q, unf_d;
  logic ones_carry, ones_borrow, tens_carry_unused, tens_borrow_unused;

  // Input and history registers are deliberately untouched by clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      enter_q      <= 1'b0;
      exit_q       <= 1'b0;
      enter_prev_q <= 1'b0;
      exit_prev_q  <= 1'b0;
    end else begin
      enter_q      <= enter;
      exit_q       <= exit;
      enter_prev_q <= enter_q;
      exit_prev_q  <= exit_q;
    end
  end

  assign ent_ev   = enter_q & ~enter_prev_q;
  assign ex_ev    = exit_q & ~exit_prev_q;
  assign only_ent = ent_ev & ~ex_ev;
  assign only_ex  = ex_ev & ~ent_ev;
  assign inc      = only_ent & (count_q != CAP);
  assign dec      = only_ex & (count_q != '0);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    state_d = state_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      state_d = ST_EMPTY;
    end else begin
      if (inc) count_d = count_q + 7'd1;
      else if (dec) count_d = count_q - 7'd1;
      if (only_ent && state_q == ST_FULL) ovf_d = 1'b1;
      if (only_ex && state_q == ST_EMPTY) unf_d = 1'b1;
      case (state_q)
        ST_EMPTY:   if (inc) state_d = (CAP == 7'd1) ? ST_FULL : ST_PARTIAL;
        ST_PARTIAL: begin
          if (inc && count_q == CAP - 7'd1) state_d = ST_FULL;
          else if (dec && count_q == 7'd1) state_d = ST_EMPTY;
        end
        ST_FULL:    if (dec) state_d = (CAP == 7'd1) ? ST_EMPTY : ST_PARTIAL;
        default:    state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      state_q <= ST_EMPTY;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      empty_q <= (state_d == ST_EMPTY);
      full_q  <= (state_d == ST_FULL);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  bcd_updown_digit u_ones (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .inc    (inc),
    .dec    (dec),
    .digit  (bcd_ones),
    .carry  (ones_carry),
    .borrow (ones_borrow)
  );

  // Count saturates at 99 or below, so the tens digit never ripples further.
  bcd_updown_digit u_tens (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .inc    (ones_carry),
    .dec    (ones_borrow),
    .digit  (bcd_tens),
    .carry  (tens_carry_unused),
    .borrow (tens_borrow_unused)
  );

  assign count         = count_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_lot_occupancy_counter.sv
// Scoreboard bench for lot_occupancy_counter: tests push expected outputs tagged with
// the cycle they are due, a negedge monitor pops and compares them.
module tb_lot_occupancy_counter;

  localparam int CAP = 20;

  logic       clk = 1'b0;
  logic       reset, enter, exit, clear;
  logic [6:0] count;
  logic [3:0] bcd_tens, bcd_ones;
  logic       empty, full, err_overflow, err_underflow;

  lot_occupancy_counter #(.CAPACITY(CAP)) dut (
    .clk           (clk),
    .reset         (reset),
    .enter         (enter),
    .exit          (exit),
    .clear         (clear),
    .count         (count),
    .bcd_tens      (bcd_tens),
    .bcd_ones      (bcd_ones),
    .empty         (empty),
    .full          (full),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    due;
    string name;
    int    cnt;
    bit    ov;
    bit    un;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   m_cnt = 0;
  bit   m_ov = 1'b0;
  bit   m_un = 1'b0;
  bit   inv_en = 1'b0;

  exp_t        mon_e;
  logic [18:0] got_v, exp_v;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: structural invariants every cycle, plus scoreboard entries that fall due.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if ((({3'b0, bcd_tens} * 7'd10 + {3'b0, bcd_ones}) !== count) || ((empty & full) !== 1'b0)) begin
        failures++;
        $display("FAIL invariant cyc=%0d got count=%0d bcd=%0d/%0d empty=%b full=%b required bcd==count and not empty&full",
                 cyc, count, bcd_tens, bcd_ones, empty, full);
      end
    end
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      got_v = {count, bcd_tens, bcd_ones, empty, full, err_overflow, err_underflow};
      exp_v = {7'(mon_e.cnt), 4'(mon_e.cnt / 10), 4'(mon_e.cnt % 10), mon_e.cnt == 0,
               mon_e.cnt == CAP, mon_e.ov, mon_e.un};
      checks++;
      if (mon_e.due != cyc || got_v !== exp_v) begin
        failures++;
        $display("FAIL %s cyc=%0d due=%0d got cnt=%0d bcd=%0d/%0d e=%b f=%b ov=%b un=%b required cnt=%0d bcd=%0d/%0d e=%b f=%b ov=%b un=%b",
                 mon_e.name, cyc, mon_e.due, got_v[18:12], got_v[11:8], got_v[7:4], got_v[3], got_v[2], got_v[1], got_v[0],
                 exp_v[18:12], exp_v[11:8], exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic expect_at(input int due, input string name);
    exp_t e;
    e.due  = due;
    e.name = name;
    e.cnt  = m_cnt;
    e.ov   = m_ov;
    e.un   = m_un;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_ov  = 1'b0;
    m_un  = 1'b0;
  endtask

  // One-cycle pulse on enter and/or exit; expects no change 1 cycle later, the update 2 cycles later.
  task automatic pulse(input logic en, input logic ex, input string name);
    int c0;
    c0 = cyc;
    expect_at(c0 + 1, {name, "_early"});
    if (en && !ex) begin
      if (m_cnt < CAP) m_cnt++;
      else m_ov = 1'b1;
    end else if (ex && !en) begin
      if (m_cnt > 0) m_cnt--;
      else m_un = 1'b1;
    end
    expect_at(c0 + 2, name);
    enter = en;
    exit  = ex;
    @(negedge clk);
    enter = 1'b0;
    exit  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    model_reset();
    inv_en = 1'b1;
    expect_at(cyc + 1, "reset_low");
    @(negedge clk);
    reset = 1'b1;
    expect_at(cyc + 1, "reset_release");
    repeat (2) @(negedge clk);
  endtask

  task automatic test_three_enters();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, $sformatf("enter3_%0d", i));
  endtask

  task automatic test_overflow();
    for (int i = 0; i < CAP - 3; i++) pulse(1'b1, 1'b0, $sformatf("fill_%0d", i));
    pulse(1'b1, 1'b1, "both_at_full");
    pulse(1'b1, 1'b0, "enter_when_full");
    pulse(1'b0, 1'b1, "exit_from_full");
  endtask

  // Clear lands in the same cycle as an enter event; clear must win and the edge must not replay.
  task automatic test_clear_priority();
    for (int i = 0; i < 12; i++) pulse(1'b0, 1'b1, $sformatf("drain_%0d", i));
    enter = 1'b1;
    expect_at(cyc + 1, "clear_pre");
    @(negedge clk);
    enter = 1'b0;
    clear = 1'b1;
    model_reset();
    expect_at(cyc + 1, "clear_vs_enter");
    expect_at(cyc + 2, "clear_no_replay");
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bcd_rollover();
    int c0;
    for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0, $sformatf("up_%0d", i));
    pulse(1'b1, 1'b0, "bcd_9_to_10");
    pulse(1'b0, 1'b1, "bcd_10_to_9");
    c0 = cyc;
    m_cnt++;
    expect_at(c0 + 2, "held_enter_once");
    enter = 1'b1;
    repeat (5) @(negedge clk);
    enter = 1'b0;
    expect_at(cyc + 1, "held_enter_still_once");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_underflow();
    reset = 1'b0;
    model_reset();
    expect_at(cyc + 1, "underflow_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pulse(1'b0, 1'b1, "exit_when_empty");
    pulse(1'b1, 1'b1, "both_at_empty");
    pulse(1'b1, 1'b0, "enter_after_underflow");
    pulse(1'b1, 1'b1, "both_at_partial");
  endtask

  // An enter event waiting in the input register when reset hits must be dropped.
  task automatic test_reset_midop();
    for (int i = 0; i < 11; i++) pulse(1'b1, 1'b0, $sformatf("to12_%0d", i));
    enter = 1'b1;
    expect_at(cyc + 1, "midop_pre");
    @(negedge clk);
    enter = 1'b0;
    reset = 1'b0;
    model_reset();
    expect_at(cyc + 1, "midop_reset");
    @(negedge clk);
    reset = 1'b1;
    expect_at(cyc + 1, "midop_no_stale_1");
    expect_at(cyc + 2, "midop_no_stale_2");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_held_through_reset();
    reset = 1'b0;
    enter = 1'b1;
    model_reset();
    expect_at(cyc + 1, "hold_reset");
    @(negedge clk);
    reset = 1'b1;
    expect_at(cyc + 1, "hold_release_early");
    m_cnt = 1;
    expect_at(cyc + 2, "hold_release_event");
    expect_at(cyc + 4, "hold_release_once");
    repeat (4) @(negedge clk);
    enter = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    enter = 1'b0;
    exit  = 1'b0;
    clear = 1'b0;
    test_reset();
    test_three_enters();
    test_overflow();
    test_clear_priority();
    test_bcd_rollover();
    test_underflow();
    test_reset_midop();
    test_held_through_reset();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
